// File: rtl/i2c_eeprom_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_eeprom_slave
// Brief    : I2C target emulating a 24LC32A-class serial EEPROM. It has a 7-bit
//            device address, a 2-byte word address, page write and sequential
//            read. SDA is open-drain: sda_oe=1 pulls the line low.
// Options  : define I2C_SLV_GLITCH_FILTER_EN to insert a 3-sample majority
//            filter after each input synchronizer. The filter adds 2 clk of
//            edge latency.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_eeprom_slave #(
    parameter logic [6:0] SLV_ADDR = 7'b1010000,
    parameter int         AWIDTH   = 12,
    parameter int         PAGE     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_pulse,
    output logic [AWIDTH-1:0] addr_ptr
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_DEVADDR = 3'd1;
    localparam logic [2:0] c_ADDR_HI = 3'd2;
    localparam logic [2:0] c_ADDR_LO = 3'd3;
    localparam logic [2:0] c_WDATA   = 3'd4;
    localparam logic [2:0] c_RDATA   = 3'd5;
    localparam logic [2:0] c_MACK    = 3'd6;
    localparam logic [2:0] c_IGNORE  = 3'd7;

    localparam int              c_DEPTH     = 2 ** AWIDTH;
    // Low pointer bits that wrap inside a page during writes
    localparam logic [AWIDTH-1:0] c_PAGE_MASK = AWIDTH'(PAGE - 1);
    localparam logic [3:0]        c_ACK_SLOT  = 4'd8;

    logic [1:0]        r_scl_sync;
    logic [1:0]        r_sda_sync;
    logic              w_scl;
    logic              w_sda;
    logic              r_scl_q;
    logic              r_sda_q;
    logic              w_scl_rise;
    logic              w_scl_fall;
    logic              w_start;
    logic              w_stop;

    logic [2:0]        r_state;
    logic [3:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_tx;
    logic [7:0]        r_addr_hi;
    logic [AWIDTH-1:0] r_addr_ptr;
    logic              r_sda_oe;
    logic              r_busy;
    logic              r_wr_pulse;

    logic [7:0]        r_mem [0:c_DEPTH-1];
    logic [7:0]        w_rd_byte;
    logic              w_mem_we;
    logic              w_addr_match;
    logic [AWIDTH-1:0] w_ptr_page_inc;

    // Two-flop synchronizers; idle bus level is high so reset to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist;
    logic [2:0] r_sda_hist;

    // Three-sample history; a 1-clk pulse never wins the majority vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
        end
    end

    assign w_scl = (r_scl_hist[0] & r_scl_hist[1]) | (r_scl_hist[0] & r_scl_hist[2]) |
                   (r_scl_hist[1] & r_scl_hist[2]);
    assign w_sda = (r_sda_hist[0] & r_sda_hist[1]) | (r_sda_hist[0] & r_sda_hist[2]) |
                   (r_sda_hist[1] & r_sda_hist[2]);
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    // Previous conditioned levels for edge and START/STOP detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_q <= 1'b1;
            r_sda_q <= 1'b1;
        end else begin
            r_scl_q <= w_scl;
            r_sda_q <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_q;
    assign w_scl_fall = ~w_scl & r_scl_q;
    // SDA may only move while SCL is high to form START/STOP
    assign w_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
    assign w_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;

    assign w_rd_byte      = r_mem[r_addr_ptr];
    assign w_addr_match   = (r_shift[7:1] == SLV_ADDR);
    assign w_ptr_page_inc = (r_addr_ptr & ~c_PAGE_MASK) |
                            ((r_addr_ptr + AWIDTH'(1)) & c_PAGE_MASK);
    // A data byte commits on the SCL rise that closes its ACK slot
    assign w_mem_we       = w_scl_rise & (r_bitcnt == c_ACK_SLOT) & (r_state == c_WDATA);

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr_ptr] <= r_shift;
        end
    end

    // Protocol FSM: bits are sampled on SCL rise, SDA drive changes on SCL fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 8'd0;
            r_tx       <= 8'd0;
            r_addr_hi  <= 8'd0;
            r_addr_ptr <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_pulse <= 1'b0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_stop) begin
                // A partially received byte is simply dropped here
                r_state  <= c_IDLE;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state  <= c_DEVADDR;
                r_bitcnt <= 4'd0;
            end else if (w_scl_rise) begin
                if (r_bitcnt != c_ACK_SLOT) begin
                    r_shift  <= {r_shift[6:0], w_sda};
                    r_bitcnt <= r_bitcnt + 4'd1;
                end else begin
                    // SCL rise inside the ACK slot: act on the completed byte
                    r_bitcnt <= 4'd0;
                    case (r_state)
                        c_DEVADDR: begin
                            if (r_shift[0]) begin
                                r_state <= c_RDATA;
                                r_tx    <= w_rd_byte;
                            end else begin
                                r_state <= c_ADDR_HI;
                            end
                        end
                        c_ADDR_HI: begin
                            r_addr_hi <= r_shift;
                            r_state   <= c_ADDR_LO;
                        end
                        c_ADDR_LO: begin
                            r_addr_ptr <= AWIDTH'({r_addr_hi, r_shift});
                            r_state    <= c_WDATA;
                        end
                        c_WDATA: begin
                            r_wr_pulse <= 1'b1;
                            r_addr_ptr <= w_ptr_page_inc;
                        end
                        c_MACK: begin
                            if (w_sda) begin
                                r_state <= c_IGNORE;
                            end else begin
                                r_state <= c_RDATA;
                                r_tx    <= w_rd_byte;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end else if (w_scl_fall) begin
                case (r_state)
                    c_DEVADDR: begin
                        if (r_bitcnt == c_ACK_SLOT) begin
                            if (w_addr_match) begin
                                r_sda_oe <= 1'b1;
                                r_busy   <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_busy   <= 1'b0;
                                r_state  <= c_IGNORE;
                            end
                        end else begin
                            r_sda_oe <= 1'b0;
                        end
                    end
                    c_ADDR_HI, c_ADDR_LO, c_WDATA: begin
                        r_sda_oe <= (r_bitcnt == c_ACK_SLOT);
                    end
                    c_RDATA: begin
                        if (r_bitcnt == c_ACK_SLOT) begin
                            // Hand SDA to the master for its ACK/NACK
                            r_sda_oe   <= 1'b0;
                            r_state    <= c_MACK;
                            r_addr_ptr <= r_addr_ptr + AWIDTH'(1);
                        end else begin
                            r_sda_oe <= ~r_tx[3'd7 - r_bitcnt[2:0]];
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_pulse = r_wr_pulse;
    assign addr_ptr = r_addr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_eeprom_slave
// Brief    : Directed bench for i2c_eeprom_slave. It uses a bit-banged I2C
//            master and a transaction-level EEPROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_eeprom_slave;

    localparam int         AW  = 12;
    localparam int         PG  = 32;
    localparam int         MEM = 4096;
    localparam logic [6:0] DEV = 7'h50;
    localparam time        QTR = 100;
    localparam time        HLF = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          scl;
    logic          msda;
    logic          sda_bus;
    logic          sda_oe;
    logic          busy;
    logic          wr_pulse;
    logic [AW-1:0] addr_ptr;

    int checks = 0;
    int errors = 0;

    assign sda_bus = msda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .SLV_ADDR (DEV),
        .AWIDTH   (AW),
        .PAGE     (PG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .addr_ptr (addr_ptr)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level EEPROM model ----------------
    logic [7:0] m_mem [0:MEM-1];
    logic [7:0] m_hi;
    int         m_ptr = 0;
    int         m_idx = 0;
    int         m_writes = 0;
    bit         m_busy = 0;
    bit         m_expect_dev = 0;
    bit         m_addressed = 0;
    bit         m_rd = 0;

    function automatic void model_start();
        m_expect_dev = 1;
    endfunction

    function automatic void model_stop();
        m_busy = 0;
        m_addressed = 0;
        m_expect_dev = 0;
    endfunction

    function automatic void model_reset();
        model_stop();
        m_ptr = 0;
    endfunction

    // Returns whether the target must ACK the byte the master just sent
    function automatic bit model_wbyte(input logic [7:0] b);
        if (m_expect_dev) begin
            m_expect_dev = 0;
            m_idx = 0;
            m_addressed = (b[7:1] == DEV);
            m_busy = m_addressed;
            m_rd = b[0];
            return m_addressed;
        end
        if (!m_addressed || m_rd) return 0;
        if (m_idx == 0) begin
            m_hi = b;
        end else if (m_idx == 1) begin
            m_ptr = int'({m_hi, b}) % MEM;
        end else begin
            m_mem[m_ptr] = b;
            m_writes++;
            m_ptr = (m_ptr / PG) * PG + ((m_ptr % PG) + 1) % PG;
        end
        m_idx++;
        return 1;
    endfunction

    function automatic logic [7:0] model_rbyte();
        logic [7:0] d;
        d = m_mem[m_ptr];
        m_ptr = (m_ptr + 1) % MEM;
        return d;
    endfunction

    // ---------------- per-cycle compare process ----------------
    bit   chk_en = 0;
    logic exp_oe = 1'b0;
    int   pulses = 0;
    logic prev_wr = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("sda_oe_bit", sda_oe, exp_oe);
            check("busy_bit", busy, m_busy);
        end
        if (wr_pulse) begin
            pulses++;
            check("wr_pulse_width", prev_wr, 1'b0);
        end
        prev_wr = wr_pulse;
    end

    // ---------------- bit-level master ----------------
    task automatic clock_bit(input logic sda_val, input logic e_oe, output logic sampled);
        msda = sda_val;
        #QTR;
        scl = 1'b1;
        exp_oe = e_oe;
        chk_en = 1;
        #HLF;
        sampled = sda_bus;
        #HLF;
        chk_en = 0;
        scl = 1'b0;
        #QTR;
    endtask

    task automatic i2c_start();
        msda = 1'b1;
        #QTR;
        scl = 1'b1;
        #QTR;
        msda = 1'b0;
        #QTR;
        scl = 1'b0;
        #QTR;
        model_start();
    endtask

    task automatic i2c_stop();
        msda = 1'b0;
        #QTR;
        scl = 1'b1;
        #QTR;
        msda = 1'b1;
        #QTR;
        model_stop();
        check("busy_after_stop", busy, 1'b0);
        check("sda_oe_after_stop", sda_oe, 1'b0);
        check("wr_count", pulses, m_writes);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lit_ack, input string nm);
        logic s;
        bit   e_ack;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0, s);
        e_ack = model_wbyte(b);
        clock_bit(1'b1, e_ack, s);
        check({nm, "_ack"}, !s, lit_ack);
    endtask

    task automatic recv_byte(input bit mack, input logic [7:0] lit, input string nm);
        logic [7:0] e;
        logic [7:0] d;
        logic       s;
        e = model_rbyte();
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, ~e[i], s);
            d[i] = s;
        end
        clock_bit(!mack, 1'b0, s);
        if (!mack) m_addressed = 0;
        check({nm, "_model"}, d, e);
        check({nm, "_lit"}, d, lit);
    endtask

    task automatic addr_then_read(input logic [7:0] hi, input logic [7:0] lo);
        i2c_start();
        send_byte(8'hA0, 1, "rd_dev_w");
        send_byte(hi, 1, "rd_ahi");
        send_byte(lo, 1, "rd_alo");
        i2c_start();
        send_byte(8'hA1, 1, "rd_dev_r");
    endtask

    int p0;

    initial begin
        scl  = 1'b1;
        msda = 1'b1;
        rst  = 1'b1;
        #101;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_pulse", wr_pulse, 1'b0);
        check("rst_addr_ptr", addr_ptr, 12'h000);
        rst = 1'b0;
        #200;

        // Page write of two bytes at 0x123
        p0 = pulses;
        i2c_start();
        send_byte(8'hA0, 1, "pw_dev");
        send_byte(8'h01, 1, "pw_ahi");
        send_byte(8'h23, 1, "pw_alo");
        send_byte(8'h55, 1, "pw_d0");
        send_byte(8'hAA, 1, "pw_d1");
        i2c_stop();
        check("pw_pulses", pulses - p0, 2);
        check("pw_ptr", addr_ptr, 12'h125);
        check("pw_ptr_model", addr_ptr, m_ptr);

        // Random read of the same two bytes
        addr_then_read(8'h01, 8'h23);
        recv_byte(1, 8'h55, "rr_b0");
        recv_byte(0, 8'hAA, "rr_b1");
        check("rr_release", sda_oe, 1'b0);
        check("rr_ptr", addr_ptr, 12'h125);
        i2c_stop();

        // Address mismatch
        p0 = pulses;
        i2c_start();
        send_byte(8'hA2, 0, "mm_dev");
        send_byte(8'h00, 0, "mm_b1");
        check("mm_busy", busy, 1'b0);
        i2c_stop();
        check("mm_pulses", pulses - p0, 0);

        // Page wrap on write starting at 0x01F
        p0 = pulses;
        i2c_start();
        send_byte(8'hA0, 1, "wp_dev");
        send_byte(8'h00, 1, "wp_ahi");
        send_byte(8'h1F, 1, "wp_alo");
        send_byte(8'h11, 1, "wp_d0");
        send_byte(8'h22, 1, "wp_d1");
        send_byte(8'h33, 1, "wp_d2");
        i2c_stop();
        check("wp_pulses", pulses - p0, 3);
        check("wp_ptr", addr_ptr, 12'h002);
        addr_then_read(8'h00, 8'h1F);
        recv_byte(0, 8'h11, "wp_rd1f");
        i2c_stop();
        addr_then_read(8'h00, 8'h00);
        recv_byte(1, 8'h22, "wp_rd00");
        recv_byte(0, 8'h33, "wp_rd01");
        i2c_stop();

        // Read wrap across the top of memory
        i2c_start();
        send_byte(8'hA0, 1, "tw_dev");
        send_byte(8'h0F, 1, "tw_ahi");
        send_byte(8'hFF, 1, "tw_alo");
        send_byte(8'h5C, 1, "tw_d0");
        i2c_stop();
        check("tw_ptr", addr_ptr, 12'hFE0);
        addr_then_read(8'h0F, 8'hFF);
        recv_byte(1, 8'h5C, "rw_fff");
        recv_byte(0, 8'h22, "rw_000");
        check("rw_ptr", addr_ptr, 12'h001);
        i2c_stop();

        // Asynchronous reset while the target drives a 0 data bit
        addr_then_read(8'h01, 8'h23);
        check("ar_driving", sda_oe, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_sda_oe", sda_oe, 1'b0);
        check("ar_busy", busy, 1'b0);
        model_reset();
        #20;
        check("ar_ptr", addr_ptr, 12'h000);
        rst = 1'b0;
        #200;
        addr_then_read(8'h01, 8'h24);
        recv_byte(0, 8'hAA, "ar_rd");
        check("ar_rd_ptr", addr_ptr, 12'h125);
        i2c_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C target that emulates a 24LC32A-class serial EEPROM: 7-bit device address, 2-byte word address, page write and sequential read.
- Responder counterpart to the APB-driven I2C master. Used in system and FPGA benches in place of the behavioural EEPROM model, and as an on-chip configuration store.
- Open-drain SDA handled by the enable-low convention: the pad drives 0 when sda_oe=1, otherwise releases the line to the pull-up.

Parameters:
SLV_ADDR, 7'b1010000, 7-bit device address the block responds to
AWIDTH, 12, memory address width; depth = 2**AWIDTH bytes
PAGE, 32, page-write size in bytes; power of two, at most 2**AWIDTH

Ports:
clk  input  1  system clock; must be at least 16x SCL frequency
rst  input  1  asynchronous active-high reset
scl_i  input  1  SCL pad input (asynchronous)
sda_i  input  1  SDA pad input (asynchronous)
sda_oe  output  1  1 = pull SDA low, 0 = release
busy  output  1  transaction addressed to this device in progress
wr_pulse  output  1  one-clk pulse per data byte committed to memory
addr_ptr  output  AWIDTH  current internal address pointer

Behaviour:
- Reset: asynchronous, active-high. sda_oe=0, busy=0, wr_pulse=0, addr_ptr=0, FSM=IDLE. Memory contents are not reset.
- Reset asserted mid-transfer releases SDA immediately, without waiting for a clk edge.
- Input conditioning: scl_i and sda_i each pass a 2-flop synchronizer. Edges are detected on the synchronized values.
- START: SDA falls while SCL is high. Accepted in any state, including a repeated START mid-transfer. Clears the bit counter and enters DEVADDR.
- STOP: SDA rises while SCL is high. Accepted in any state. Goes to IDLE, sets sda_oe=0, busy=0.
- Bit timing:
  - SDA is sampled on the clk after a synchronized SCL rising edge.
  - sda_oe changes only on the clk after a synchronized SCL falling edge. It holds through the SCL high phase.
- Bytes are MSB first. A 4-bit counter counts 0-8; count 8 is the ACK slot.
- FSM states: IDLE, DEVADDR, ADDR_HI, ADDR_LO, WDATA, RDATA, MACK, IGNORE. Each receive state includes its ACK slot.
- DEVADDR:
  - Address[7:1] matches SLV_ADDR: ACK, set busy=1.
  - R/W=0: go to ADDR_HI.
  - R/W=1: go to RDATA (current-address read).
  - Mismatch: no ACK, go to IGNORE until the next START or STOP.
- ADDR_HI / ADDR_LO: each byte is ACKed. The 16-bit word address is truncated to its low AWIDTH bits and loaded into addr_ptr at the ADDR_LO ACK. Then go to WDATA.
- WDATA, on each byte:
  - Write mem[addr_ptr], pulse wr_pulse at the ACK slot, and ACK.
  - Increment addr_ptr within the page: the low log2(PAGE) bits wrap, the upper bits are held.
- RDATA:
  - Load shift register from mem[addr_ptr] on entry, and after each master ACK.
  - Drive sda_oe = ~bit for 8 bits, then release SDA for the master ACK slot (MACK).
  - addr_ptr increments with full wrap over 2**AWIDTH.
- MACK: SDA low means continue in RDATA. SDA high (NACK) means go to IGNORE and keep SDA released.
- Writes commit immediately; there is no write-cycle NACK period.
- STOP received during a partial byte discards that byte.

Optional Feature:
- I2C_SLV_GLITCH_FILTER_EN defined: a 3-sample majority filter follows each synchronizer.
  - Suppresses pulses up to 1 clk wide.
  - Adds 2 clk of latency to all edge detection.
- Undefined: no filter; synchronizer output is used directly.

Test Plan:
- Page write: START, 0xA0, 0x01, 0x23, 0x55, 0xAA, STOP -> ACK on all 5 bytes; 2 wr_pulse; mem[0x123]=0x55, mem[0x124]=0xAA; busy falls at STOP.
- Random read after the page write: START, 0xA0, 0x01, 0x23, repeated START, 0xA1, then master ACK, then master NACK -> bytes returned 0x55 then 0xAA; SDA released after the NACK; addr_ptr=0x125.
- Address mismatch: START, 0xA2, 0x00 -> sda_oe stays 0 throughout; busy=0; no wr_pulse.
- Page wrap: write at 0x01F with data 0x11, 0x22, 0x33 -> mem[0x01F]=0x11, mem[0x000]=0x22, mem[0x001]=0x33.
- Read wrap: pointer at 0xFFF, sequential read of 2 bytes -> mem[0xFFF] then mem[0x000].
- Async reset while driving a 0 data bit -> sda_oe=0 before the next clk edge; busy=0; the next START is decoded normally.
